// File: rtl/ifetch_unit_pkg.sv
// ifetch_unit_pkg: shared definitions for the instruction fetch unit.
// Holds the datapath width, the default reset PC, the fetch FSM state
// encoding and the sequential-PC helper used by the fetch logic.
package ifetch_unit_pkg;

  localparam int unsigned DATA_WIDTH = 32;

  localparam logic [DATA_WIDTH-1:0] RESET_PC_DEFAULT = '0;
  localparam logic [DATA_WIDTH-1:0] PC_STEP          = 32'd4;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } fetch_state_t;

  // Sequential PC; the add wraps naturally modulo 2^DATA_WIDTH.
  function automatic logic [DATA_WIDTH-1:0] next_pc(input logic [DATA_WIDTH-1:0] pc);
    return pc + PC_STEP;
  endfunction

endpackage

// File: rtl/ifetch_unit_if.sv
// ifetch_unit_if: bundles every fetch-unit connection except clock, reset and
// the global enable.
//   ICache lookup : addr1 (PC under lookup), hit, returnInst
//   ICache fill   : insqueue_to_ICache_needchange (write strobe), addr2, storeInst
//   Memory        : mem_req (level), mem_addr, mem_done (1-cycle pulse), mem_data
//   Queue         : ins_valid (push strobe), ins_pc, ins_data, queue_full
//   Redirect      : jump_flag (1-cycle pulse), jump_pc
// master = fetch unit side, slave = cache / memory / queue / redirect side.
interface ifetch_unit_if;
  import ifetch_unit_pkg::*;

  logic [DATA_WIDTH-1:0] addr1;
  logic                  hit;
  logic [DATA_WIDTH-1:0] returnInst;

  logic                  insqueue_to_ICache_needchange;
  logic [DATA_WIDTH-1:0] addr2;
  logic [DATA_WIDTH-1:0] storeInst;

  logic                  mem_req;
  logic [DATA_WIDTH-1:0] mem_addr;
  logic                  mem_done;
  logic [DATA_WIDTH-1:0] mem_data;

  logic                  ins_valid;
  logic [DATA_WIDTH-1:0] ins_pc;
  logic [DATA_WIDTH-1:0] ins_data;
  logic                  queue_full;

  logic                  jump_flag;
  logic [DATA_WIDTH-1:0] jump_pc;

  modport master (
    output addr1, insqueue_to_ICache_needchange, addr2, storeInst,
           mem_req, mem_addr, ins_valid, ins_pc, ins_data,
    input  hit, returnInst, mem_done, mem_data, queue_full,
           jump_flag, jump_pc
  );

  modport slave (
    input  addr1, insqueue_to_ICache_needchange, addr2, storeInst,
           mem_req, mem_addr, ins_valid, ins_pc, ins_data,
    output hit, returnInst, mem_done, mem_data, queue_full,
           jump_flag, jump_pc
  );

endinterface

// File: rtl/ifetch_unit.sv
// ifetch_unit: instruction fetch stage.
// Looks up the current PC in the ICache every cycle. On a hit with queue
// space it pushes {pc, instruction} to the instruction queue and advances
// the PC by 4. On a miss it issues a memory read, waits for mem_done, writes
// the returned word into the ICache and then re-fetches the same PC (which
// now hits). A jump_flag pulse redirects the PC; an outstanding memory read
// is never cancelled and its fill always completes.
// Ports:
//   clk  : clock, all state changes on posedge
//   rst  : asynchronous active-low reset
//   rdy  : global enable; low freezes all state and suppresses strobes
//   bus  : ifetch_unit_if.master (ICache, memory, queue, redirect signals)
module ifetch_unit
  import ifetch_unit_pkg::*;
#(
  parameter logic [DATA_WIDTH-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          rdy,
  ifetch_unit_if.master bus
);

  fetch_state_t          r_state;
  logic [DATA_WIDTH-1:0] r_pc;
  logic                  r_mem_req;
  logic [DATA_WIDTH-1:0] r_mem_addr;
  logic                  r_ins_valid;
  logic [DATA_WIDTH-1:0] r_ins_pc;
  logic [DATA_WIDTH-1:0] r_ins_data;
  logic                  r_needchange;
  logic [DATA_WIDTH-1:0] r_addr2;
  logic [DATA_WIDTH-1:0] r_store_inst;

  logic [DATA_WIDTH-1:0] w_pc_next;

  assign w_pc_next = next_pc(r_pc);

  assign bus.addr1                         = r_pc;
  assign bus.mem_req                       = r_mem_req;
  assign bus.mem_addr                      = r_mem_addr;
  assign bus.ins_valid                     = r_ins_valid;
  assign bus.ins_pc                        = r_ins_pc;
  assign bus.ins_data                      = r_ins_data;
  assign bus.insqueue_to_ICache_needchange = r_needchange;
  assign bus.addr2                         = r_addr2;
  assign bus.storeInst                     = r_store_inst;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= ST_IDLE;
      r_pc         <= RESET_PC;
      r_mem_req    <= 1'b0;
      r_mem_addr   <= '0;
      r_ins_valid  <= 1'b0;
      r_ins_pc     <= '0;
      r_ins_data   <= '0;
      r_needchange <= 1'b0;
      r_addr2      <= '0;
      r_store_inst <= '0;
    end else if (!rdy) begin
      // Frozen: state, pc and the memory request hold; strobes drop.
      r_ins_valid  <= 1'b0;
      r_needchange <= 1'b0;
    end else begin
      r_ins_valid  <= 1'b0;
      r_needchange <= 1'b0;

      case (r_state)
        ST_IDLE: begin
          if (bus.jump_flag) begin
            r_pc <= bus.jump_pc;
          end else if (bus.queue_full || r_needchange) begin
            // Hold. While the fill strobe is out the cache has not yet
            // absorbed the new line, so a lookup now would re-miss on the
            // line being written; wait one cycle for the refetch to hit.
          end else if (bus.hit) begin
            r_ins_valid <= 1'b1;
            r_ins_pc    <= r_pc;
            r_ins_data  <= bus.returnInst;
            r_pc        <= w_pc_next;
          end else begin
            r_mem_req  <= 1'b1;
            r_mem_addr <= r_pc;
            r_state    <= ST_WAIT;
          end
        end

        ST_WAIT: begin
          if (bus.jump_flag) begin
            r_pc <= bus.jump_pc;
          end
          if (bus.mem_done) begin
            r_mem_req    <= 1'b0;
            r_needchange <= 1'b1;
            r_addr2      <= r_mem_addr;
            r_store_inst <= bus.mem_data;
            r_state      <= ST_IDLE;
          end
        end

        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ifetch_unit.sv
// tb_ifetch_unit: directed scoreboard bench for ifetch_unit.
// A small direct-mapped ICache model answers lookups and absorbs fills.
// The stimulus process queues expected pushes/fills; a negedge monitor pops
// and compares whenever the DUT strobes ins_valid or the fill strobe.
module tb_ifetch_unit;
  import ifetch_unit_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic rdy;

  ifetch_unit_if bus();

  ifetch_unit #(.RESET_PC(32'h0)) dut (
    .clk (clk),
    .rst (rst),
    .rdy (rdy),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
  } pair_t;

  pair_t exp_ins[$];
  pair_t exp_fill[$];
  pair_t mon_i;
  pair_t mon_f;

  // ICache model: 256 direct-mapped entries, full-address tags.
  logic        c_val  [256];
  logic [31:0] c_tag  [256];
  logic [31:0] c_data [256];
  logic        cache_clr;
  logic        pre_we;
  logic [31:0] pre_addr;
  logic [31:0] pre_data;

  always @(posedge clk) begin
    if (cache_clr) begin
      for (int i = 0; i < 256; i++) c_val[i] <= 1'b0;
    end else if (pre_we) begin
      c_val[pre_addr[9:2]]  <= 1'b1;
      c_tag[pre_addr[9:2]]  <= pre_addr;
      c_data[pre_addr[9:2]] <= pre_data;
    end else if (bus.insqueue_to_ICache_needchange) begin
      c_val[bus.addr2[9:2]]  <= 1'b1;
      c_tag[bus.addr2[9:2]]  <= bus.addr2;
      c_data[bus.addr2[9:2]] <= bus.storeInst;
    end
  end

  always_comb begin
    bus.hit        = c_val[bus.addr1[9:2]] && (c_tag[bus.addr1[9:2]] == bus.addr1);
    bus.returnInst = c_data[bus.addr1[9:2]];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every strobe must match the head of its expectation queue.
  always @(negedge clk) begin
    if (bus.ins_valid === 1'b1) begin
      if (exp_ins.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_push: ins_pc %h ins_data %h, expected no push",
                 bus.ins_pc, bus.ins_data);
      end else begin
        mon_i = exp_ins.pop_front();
        chk("push_pc", bus.ins_pc, mon_i.a);
        chk("push_data", bus.ins_data, mon_i.d);
      end
    end
    if (bus.insqueue_to_ICache_needchange === 1'b1) begin
      if (exp_fill.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_fill: addr2 %h storeInst %h, expected no fill",
                 bus.addr2, bus.storeInst);
      end else begin
        mon_f = exp_fill.pop_front();
        chk("fill_addr", bus.addr2, mon_f.a);
        chk("fill_data", bus.storeInst, mon_f.d);
      end
    end
  end

  task automatic expect_ins(input logic [31:0] a, input logic [31:0] d);
    pair_t p;
    p.a = a;
    p.d = d;
    exp_ins.push_back(p);
  endtask

  task automatic expect_fill(input logic [31:0] a, input logic [31:0] d);
    pair_t p;
    p.a = a;
    p.d = d;
    exp_fill.push_back(p);
  endtask

  // One-cycle redirect while idle and backpressured.
  task automatic jump_to(input logic [31:0] a);
    bus.jump_flag = 1'b1;
    bus.jump_pc   = a;
    @(negedge clk);
    bus.jump_flag = 1'b0;
    bus.jump_pc   = '0;
  endtask

  // mem_done pulse, then fill cycle, settle cycle, refetch push; backpressure
  // is raised right after the push so the next PC is not fetched.
  task automatic mem_respond(input logic [31:0] d);
    bus.mem_done = 1'b1;
    bus.mem_data = d;
    @(negedge clk);
    bus.mem_done = 1'b0;
    bus.mem_data = '0;
    chk("req_dropped", 32'(bus.mem_req), 32'd0);
    @(negedge clk);
    chk("no_rerequest", 32'(bus.mem_req), 32'd0);
    @(negedge clk);
    bus.queue_full = 1'b1;
    @(negedge clk);
  endtask

  logic [31:0] pl_a [6];
  logic [31:0] pl_d [6];

  initial begin
    pl_a = '{32'h0000_0000, 32'h0000_0004, 32'h0000_0008, 32'h0000_000C,
             32'h0000_0040, 32'hFFFF_FFFC};
    pl_d = '{32'h0000_0013, 32'h0010_0093, 32'h0020_8113, 32'h0031_0193,
             32'h0400_0513, 32'hFFC0_0F13};

    rst            = 1'b0;
    rdy            = 1'b1;
    bus.queue_full = 1'b1;
    bus.jump_flag  = 1'b0;
    bus.jump_pc    = '0;
    bus.mem_done   = 1'b0;
    bus.mem_data   = '0;
    cache_clr      = 1'b1;
    pre_we         = 1'b0;
    pre_addr       = '0;
    pre_data       = '0;

    @(negedge clk);
    cache_clr = 1'b0;
    for (int i = 0; i < 6; i++) begin
      pre_we   = 1'b1;
      pre_addr = pl_a[i];
      pre_data = pl_d[i];
      @(negedge clk);
    end
    pre_we = 1'b0;

    // Reset state
    chk("rst_pc", bus.addr1, 32'h0);
    chk("rst_mem_req", 32'(bus.mem_req), 32'd0);
    chk("rst_mem_addr", bus.mem_addr, 32'h0);
    chk("rst_ins_valid", 32'(bus.ins_valid), 32'd0);
    chk("rst_ins_pc", bus.ins_pc, 32'h0);
    chk("rst_ins_data", bus.ins_data, 32'h0);
    chk("rst_needchange", 32'(bus.insqueue_to_ICache_needchange), 32'd0);
    chk("rst_addr2", bus.addr2, 32'h0);
    chk("rst_storeInst", bus.storeInst, 32'h0);

    rst = 1'b1;

    // Backpressure on a hit: pc holds, nothing pushed
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_pc", bus.addr1, 32'h0);
      chk("bp_no_req", 32'(bus.mem_req), 32'd0);
    end

    // Release: warm stream 0,4,8,C on consecutive cycles
    for (int i = 0; i < 4; i++) expect_ins(pl_a[i], pl_d[i]);
    bus.queue_full = 1'b0;
    repeat (4) @(negedge clk);
    bus.queue_full = 1'b1;
    @(negedge clk);
    chk("stream_pc", bus.addr1, 32'h10);
    chk("stream_no_req", 32'(bus.mem_req), 32'd0);

    // Cold miss at 0x100, mem_done three cycles after the request
    jump_to(32'h100);
    chk("jump_pc", bus.addr1, 32'h100);
    expect_fill(32'h100, 32'h00A0_0093);
    expect_ins(32'h100, 32'h00A0_0093);
    bus.queue_full = 1'b0;
    @(negedge clk);
    chk("miss_req", 32'(bus.mem_req), 32'd1);
    chk("miss_addr", bus.mem_addr, 32'h100);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("wait_req", 32'(bus.mem_req), 32'd1);
      chk("wait_addr", bus.mem_addr, 32'h100);
    end
    mem_respond(32'h00A0_0093);
    chk("miss_next_pc", bus.addr1, 32'h104);

    // Redirect while waiting: fill of 0x200 still lands, fetch resumes at 0x40
    jump_to(32'h200);
    expect_fill(32'h200, 32'h0020_0113);
    expect_ins(32'h40, 32'h0400_0513);
    bus.queue_full = 1'b0;
    @(negedge clk);
    chk("redir_addr", bus.mem_addr, 32'h200);
    bus.jump_flag = 1'b1;
    bus.jump_pc   = 32'h40;
    @(negedge clk);
    bus.jump_flag = 1'b0;
    bus.jump_pc   = '0;
    chk("redir_pc", bus.addr1, 32'h40);
    chk("redir_req_kept", 32'(bus.mem_req), 32'd1);
    chk("redir_addr_kept", bus.mem_addr, 32'h200);
    mem_respond(32'h0020_0113);
    chk("redir_next_pc", bus.addr1, 32'h44);

    // rdy low in WAIT with mem_done/jump held: nothing happens; on rdy
    // return the fill completes together with a coincident jump to 0x0
    jump_to(32'h300);
    bus.queue_full = 1'b0;
    @(negedge clk);
    chk("stall_req", 32'(bus.mem_req), 32'd1);
    rdy           = 1'b0;
    bus.mem_done  = 1'b1;
    bus.mem_data  = 32'h0030_0193;
    bus.jump_flag = 1'b1;
    bus.jump_pc   = 32'h500;
    repeat (2) @(negedge clk);
    chk("stall_req_held", 32'(bus.mem_req), 32'd1);
    chk("stall_addr_held", bus.mem_addr, 32'h300);
    chk("stall_pc_held", bus.addr1, 32'h300);
    expect_fill(32'h300, 32'h0030_0193);
    expect_ins(32'h0, 32'h0000_0013);
    rdy         = 1'b1;
    bus.jump_pc = 32'h0;
    @(negedge clk);
    bus.mem_done  = 1'b0;
    bus.mem_data  = '0;
    bus.jump_flag = 1'b0;
    chk("coinc_pc", bus.addr1, 32'h0);
    chk("coinc_req", 32'(bus.mem_req), 32'd0);
    @(negedge clk);
    @(negedge clk);
    bus.queue_full = 1'b1;
    @(negedge clk);
    chk("coinc_next_pc", bus.addr1, 32'h4);

    // Asynchronous reset mid-request, then a stray mem_done
    jump_to(32'h400);
    bus.queue_full = 1'b0;
    @(negedge clk);
    chk("ar_req", 32'(bus.mem_req), 32'd1);
    bus.queue_full = 1'b1;
    #2;
    rst = 1'b0;
    #1;
    chk("ar_req_clear", 32'(bus.mem_req), 32'd0);
    chk("ar_pc", bus.addr1, 32'h0);
    chk("ar_addr_clear", bus.mem_addr, 32'h0);
    @(negedge clk);
    rst          = 1'b1;
    bus.mem_done = 1'b1;
    bus.mem_data = 32'h1234_5678;
    @(negedge clk);
    bus.mem_done = 1'b0;
    bus.mem_data = '0;
    chk("stray_no_req", 32'(bus.mem_req), 32'd0);
    @(negedge clk);
    chk("stray_pc", bus.addr1, 32'h0);

    // PC wrap from 0xFFFFFFFC
    jump_to(32'hFFFF_FFFC);
    chk("wrap_jump", bus.addr1, 32'hFFFF_FFFC);
    expect_ins(32'hFFFF_FFFC, 32'hFFC0_0F13);
    bus.queue_full = 1'b0;
    @(negedge clk);
    bus.queue_full = 1'b1;
    @(negedge clk);
    chk("wrap_pc", bus.addr1, 32'h0);

    repeat (2) @(negedge clk);
    chk("ins_queue_drained", 32'(exp_ins.size()), 32'd0);
    chk("fill_queue_drained", 32'(exp_fill.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
